// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with standard or first-word-fall-through read, fill level, almost-flags,
// sticky overflow/underflow and synchronous flush. All flags are registered from next-count.
module sync_fifo_v2 #(
   parameter int DATA_WIDTH   = 128,
   parameter int DEPTH        = 1024,
   parameter int ADDR_W       = $clog2(DEPTH),
   parameter bit FWFT         = 1'b0,
   parameter int ALM_FULL_TH  = 4,
   parameter int ALM_EMPTY_TH = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  i_wren,
   input  logic [DATA_WIDTH-1:0] i_wrdata,
   input  logic                  i_rden,
   output logic [DATA_WIDTH-1:0] o_rddata,
   output logic                  o_rdvalid,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_alm_full,
   output logic                  o_alm_empty,
   output logic [ADDR_W:0]       o_count,
   input  logic                  i_flush,
   input  logic                  i_clr_err,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_v2: DEPTH must be a power of two >= 4");
   end
   if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr_w
      $error("sync_fifo_v2: ADDR_W is derived from DEPTH and must not be overridden");
   end
   if (ALM_FULL_TH < 1 || ALM_FULL_TH > DEPTH - 1) begin : g_bad_af_th
      $error("sync_fifo_v2: ALM_FULL_TH out of range 1..DEPTH-1");
   end
   if (ALM_EMPTY_TH < 0 || ALM_EMPTY_TH > DEPTH - 1) begin : g_bad_ae_th
      $error("sync_fifo_v2: ALM_EMPTY_TH out of range 0..DEPTH-1");
   end

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_LVL  = (ADDR_W+1)'(DEPTH - ALM_FULL_TH);
   localparam logic [ADDR_W:0] AE_LVL  = (ADDR_W+1)'(ALM_EMPTY_TH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_W-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [ADDR_W:0]       count_q, count_nxt;
   logic                  full_q, empty_q, alm_full_q, alm_empty_q;
   logic                  ovf_q, unf_q, rdvalid_q;
   logic [DATA_WIDTH-1:0] rddata_q, head_nxt;
   logic                  wr_acc, rd_acc;

   // Flush drops both requests, so neither is accepted nor counted as an error.
   assign wr_acc = i_wren & ~full_q & ~i_flush;
   assign rd_acc = i_rden & ~empty_q & ~i_flush;

   always_comb begin
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      count_nxt  = count_q;
      if (i_flush) begin
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
         count_nxt  = '0;
      end else begin
         if (wr_acc) wr_ptr_nxt = wr_ptr + ADDR_W'(1);
         if (rd_acc) rd_ptr_nxt = rd_ptr + ADDR_W'(1);
         if (wr_acc && !rd_acc)      count_nxt = count_q + (ADDR_W+1)'(1);
         else if (rd_acc && !wr_acc) count_nxt = count_q - (ADDR_W+1)'(1);
      end
   end

   // In FWFT mode the next head may be the word being written this cycle.
   assign head_nxt = (wr_acc && (wr_ptr == rd_ptr_nxt)) ? i_wrdata : mem[rd_ptr_nxt];

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= i_wrdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         alm_full_q  <= 1'b0;
         alm_empty_q <= 1'b1;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         rdvalid_q   <= 1'b0;
         rddata_q    <= '0;
      end else begin
         wr_ptr      <= wr_ptr_nxt;
         rd_ptr      <= rd_ptr_nxt;
         count_q     <= count_nxt;
         full_q      <= (count_nxt == DEPTH_C);
         empty_q     <= (count_nxt == '0);
         alm_full_q  <= (count_nxt >= AF_LVL);
         alm_empty_q <= (count_nxt <= AE_LVL);
         ovf_q       <= (i_wren & full_q & ~i_flush) | (ovf_q & ~i_clr_err);
         unf_q       <= (i_rden & empty_q & ~i_flush) | (unf_q & ~i_clr_err);
         rdvalid_q   <= rd_acc;
         if (FWFT) begin
            if (count_nxt != '0) rddata_q <= head_nxt;
         end else if (rd_acc) begin
            rddata_q <= mem[rd_ptr];
         end
      end
   end

   assign o_rddata    = rddata_q;
   assign o_rdvalid   = FWFT ? ~empty_q : rdvalid_q;
   assign o_full      = full_q;
   assign o_empty     = empty_q;
   assign o_alm_full  = alm_full_q;
   assign o_alm_empty = alm_empty_q;
   assign o_count     = count_q;
   assign o_overflow  = ovf_q;
   assign o_underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Bench for sync_fifo_v2: standard and FWFT instances share one stimulus stream and one queue model.
module tb_sync_fifo_v2;
   localparam int DW = 32;
   localparam int DP = 16;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic          i_wren = 1'b0, i_rden = 1'b0, i_flush = 1'b0, i_clr_err = 1'b0;
   logic [DW-1:0] i_wrdata = '0;

   logic [DW-1:0] s_rddata, f_rddata;
   logic          s_rdvalid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
   logic          f_rdvalid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic [AW:0]   s_count, f_count;

   sync_fifo_v2 #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(1'b0), .ALM_FULL_TH(4), .ALM_EMPTY_TH(2)) u_std (
      .clk(clk), .rstn(rstn), .i_wren(i_wren), .i_wrdata(i_wrdata), .i_rden(i_rden),
      .o_rddata(s_rddata), .o_rdvalid(s_rdvalid), .o_full(s_full), .o_empty(s_empty),
      .o_alm_full(s_af), .o_alm_empty(s_ae), .o_count(s_count), .i_flush(i_flush),
      .i_clr_err(i_clr_err), .o_overflow(s_ovf), .o_underflow(s_unf));

   sync_fifo_v2 #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(1'b1), .ALM_FULL_TH(4), .ALM_EMPTY_TH(2)) u_fw (
      .clk(clk), .rstn(rstn), .i_wren(i_wren), .i_wrdata(i_wrdata), .i_rden(i_rden),
      .o_rddata(f_rddata), .o_rdvalid(f_rdvalid), .o_full(f_full), .o_empty(f_empty),
      .o_alm_full(f_af), .o_alm_empty(f_ae), .o_count(f_count), .i_flush(i_flush),
      .i_clr_err(i_clr_err), .o_overflow(f_ovf), .o_underflow(f_unf));

   int n_chk = 0;
   int n_fail = 0;

   // Behavioural model: a queue of stored words plus sticky flags and the last word read.
   logic [DW-1:0] q[$];
   bit            m_ovf, m_unf, m_rv;
   logic [DW-1:0] m_rd;

   typedef struct {
      bit          wr;
      logic [31:0] d;
      bit          rd;
      bit          fl;
      bit          clr;
      int          e_cnt;
      bit          e_empty;
      bit          e_ae;
      bit          e_rv;
      logic [31:0] e_rd;
      bit          e_unf;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = '0;
   endtask

   task automatic model_step();
      bit full, empty;
      full  = (q.size() == DP);
      empty = (q.size() == 0);
      m_rv  = 0;
      if (i_flush) begin
         q.delete();
         m_ovf = m_ovf && !i_clr_err;
         m_unf = m_unf && !i_clr_err;
      end else begin
         if (i_rden && !empty) begin
            m_rd = q.pop_front();
            m_rv = 1;
         end
         if (i_wren && !full) q.push_back(i_wrdata);
         m_ovf = (i_wren && full) || (m_ovf && !i_clr_err);
         m_unf = (i_rden && empty) || (m_unf && !i_clr_err);
      end
   endtask

   task automatic check_all();
      int n = q.size();
      chk("count", 32'(s_count), n);
      chk("empty", s_empty, n == 0);
      chk("full", s_full, n == DP);
      chk("alm_full", s_af, n >= DP - 4);
      chk("alm_empty", s_ae, n <= 2);
      chk("overflow", s_ovf, m_ovf);
      chk("underflow", s_unf, m_unf);
      chk("rdvalid", s_rdvalid, m_rv);
      chk("rddata", s_rddata, m_rd);
      chk("fw_count", 32'(f_count), n);
      chk("fw_overflow", f_ovf, m_ovf);
      chk("fw_underflow", f_unf, m_unf);
      chk("fw_rdvalid", f_rdvalid, n != 0);
      if (n != 0) chk("fw_rddata", f_rddata, q[0]);
   endtask

   task automatic cyc(input bit wr, input logic [31:0] d, input bit rd, input bit fl, input bit clr);
      i_wren = wr; i_wrdata = d; i_rden = rd; i_flush = fl; i_clr_err = clr;
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   vec_t tbl[10];

   initial begin
      tbl[0] = '{1, 32'hA0, 0, 0, 0, 1, 0, 1, 0, 32'h0,  0};
      tbl[1] = '{0, 32'h0,  1, 0, 0, 0, 1, 1, 1, 32'hA0, 0};
      tbl[2] = '{0, 32'h0,  1, 0, 0, 0, 1, 1, 0, 32'hA0, 1};
      tbl[3] = '{1, 32'hB1, 1, 0, 0, 1, 0, 1, 0, 32'hA0, 1};
      tbl[4] = '{0, 32'h0,  0, 0, 1, 1, 0, 1, 0, 32'hA0, 0};
      tbl[5] = '{1, 32'hC2, 1, 0, 0, 1, 0, 1, 1, 32'hB1, 0};
      tbl[6] = '{1, 32'hD3, 0, 0, 0, 2, 0, 1, 0, 32'hB1, 0};
      tbl[7] = '{1, 32'hE4, 0, 0, 0, 3, 0, 0, 0, 32'hB1, 0};
      tbl[8] = '{0, 32'h0,  1, 0, 1, 2, 0, 1, 1, 32'hC2, 0};
      tbl[9] = '{1, 32'hF5, 1, 1, 0, 0, 1, 1, 0, 32'hC2, 0};

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_empty", s_empty, 1);
      chk("rst_count", 32'(s_count), 0);
      @(negedge clk) rstn = 1'b1;
      @(posedge clk);
      #1;

      // Short directed sequence with hand-computed expectations
      for (int i = 0; i < 10; i++) begin
         cyc(tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].fl, tbl[i].clr);
         chk($sformatf("vec%0d_count", i), 32'(s_count), tbl[i].e_cnt);
         chk($sformatf("vec%0d_empty", i), s_empty, tbl[i].e_empty);
         chk($sformatf("vec%0d_alm_empty", i), s_ae, tbl[i].e_ae);
         chk($sformatf("vec%0d_rdvalid", i), s_rdvalid, tbl[i].e_rv);
         chk($sformatf("vec%0d_rddata", i), s_rddata, tbl[i].e_rd);
         chk($sformatf("vec%0d_underflow", i), s_unf, tbl[i].e_unf);
      end

      // Asynchronous reset in the middle of a write burst
      for (int i = 0; i < 3; i++) cyc(1, 32'h100 + i, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      i_wren = 1'b1; i_wrdata = 32'h1FF;
      #2 rstn = 1'b0;
      #1;
      chk("arst_empty", s_empty, 1);
      chk("arst_alm_empty", s_ae, 1);
      chk("arst_count", 32'(s_count), 0);
      chk("arst_full", s_full, 0);
      chk("arst_alm_full", s_af, 0);
      chk("arst_ovf", s_ovf, 0);
      chk("arst_unf", s_unf, 0);
      chk("arst_rddata", s_rddata, 0);
      chk("arst_rdvalid", s_rdvalid, 0);
      chk("arst_fw_rdvalid", f_rdvalid, 0);
      model_reset();
      i_wren = 1'b0;
      @(negedge clk) rstn = 1'b1;

      // Fill past full, then drain past empty
      for (int i = 0; i < 17; i++) cyc(1, i, 0, 0, 0);
      chk("fill_overflow", s_ovf, 1);
      chk("fill_count", 32'(s_count), 16);
      for (int i = 0; i < 17; i++) cyc(0, 0, 1, 0, 0);
      chk("drain_underflow", s_unf, 1);
      chk("drain_empty", s_empty, 1);
      cyc(0, 0, 0, 0, 1);
      chk("clr_ovf", s_ovf, 0);
      chk("clr_unf", s_unf, 0);

      // Steady state at count 8 across pointer wrap, then read+write while full
      for (int i = 0; i < 8; i++) cyc(1, 32'h200 + i, 0, 0, 0);
      for (int i = 0; i < 40; i++) cyc(1, 32'h300 + i, 1, 0, 0);
      chk("stream_count", 32'(s_count), 8);
      for (int i = 0; i < 8; i++) cyc(1, 32'h400 + i, 0, 0, 0);
      cyc(1, 32'h999, 1, 0, 0);
      chk("full_rw_count", 32'(s_count), 15);
      chk("full_rw_ovf", s_ovf, 1);

      // Flush at count 10 with a concurrent write; overflow stays set
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);
      chk("preflush_count", 32'(s_count), 10);
      cyc(1, 32'h555, 0, 1, 0);
      chk("flush_count", 32'(s_count), 0);
      chk("flush_empty", s_empty, 1);
      chk("flush_ovf_kept", s_ovf, 1);
      cyc(1, 32'h777, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      chk("post_flush_data", s_rddata, 32'h777);

      // FWFT fall-through of a single word
      cyc(0, 0, 0, 0, 1);
      cyc(1, 32'hA5, 0, 0, 0);
      chk("fwft_empty", f_empty, 0);
      chk("fwft_rdvalid", f_rdvalid, 1);
      chk("fwft_rddata", f_rddata, 32'hA5);
      cyc(0, 0, 0, 0, 0);
      chk("fwft_hold", f_rddata, 32'hA5);
      cyc(0, 0, 1, 0, 0);
      chk("fwft_pop_empty", f_empty, 1);

      // Randomized traffic with phases biased toward full and toward empty
      for (int i = 0; i < 800; i++) begin
         int wp;
         wp = ((i / 100) % 2 == 0) ? 70 : 30;
         cyc($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < 50,
             $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo_v2.md
Name: sync_fifo_v2

Overview:
Parametrised single-clock FIFO and next generation of the team's 128-bit buffer. Generalises data width and depth, and adds:
- selectable standard or first-word-fall-through (FWFT) read mode
- runtime fill level and programmable almost-flags
- sticky overflow/underflow error flags
- synchronous flush

Sits between producer and consumer stages of the datapath in the same clock domain.

Parameters:
DATA_WIDTH, 128, width of each stored word
DEPTH, 1024, number of entries; power of two, >= 4
ADDR_W, $clog2(DEPTH), pointer width (derived; do not override)
FWFT, 0, 0 = standard 1-cycle read latency, 1 = first-word-fall-through
ALM_FULL_TH, 4, o_alm_full when free slots <= ALM_FULL_TH; legal range 1..DEPTH-1
ALM_EMPTY_TH, 2, o_alm_empty when count <= ALM_EMPTY_TH; legal range 0..DEPTH-1

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  reset; one clock; reset is asynchronous and active-low
i_wren  in  1  write request
i_wrdata  in  DATA_WIDTH  write data
i_rden  in  1  read request (FWFT: pop head)
o_rddata  out  DATA_WIDTH  read data
o_rdvalid  out  1  standard: 1-cycle pulse marking o_rddata valid; FWFT: equals !o_empty
o_full  out  1  count == DEPTH
o_empty  out  1  count == 0
o_alm_full  out  1  count >= DEPTH-ALM_FULL_TH (stays high while full)
o_alm_empty  out  1  count <= ALM_EMPTY_TH (stays high while empty)
o_count  out  ADDR_W+1  current number of stored words
i_flush  in  1  synchronous flush
i_clr_err  in  1  clears sticky error flags
o_overflow  out  1  sticky: write attempted while full
o_underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rstn low, asynchronous, any cycle, including mid-transfer):
  - pointers and o_count to 0
  - o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0
  - o_rddata=0, o_rdvalid=0, o_overflow=0, o_underflow=0
  - memory contents not reset
- Write accept = i_wren & !o_full. Read accept = i_rden & !o_empty. Both use flag values registered at the start of the cycle.
- Full with i_wren&i_rden: read accepted, write rejected, overflow set. Empty with both: write accepted, read rejected, underflow set.
- Both accepted in one cycle: count unchanged, pointers both advance.
- Pointers ADDR_W bits, wrap DEPTH-1 -> 0. o_count = count register, ADDR_W+1 bits, never exceeds DEPTH.
- All flags are registered and computed from next-count, so they are consistent with o_count in every cycle. No combinational input-to-flag paths.
- Standard mode (FWFT=0):
  - o_rddata updates to the head word one cycle after read accept; o_rdvalid pulses high for that cycle.
  - o_rddata holds its value otherwise.
- FWFT mode (FWFT=1):
  - Whenever o_empty=0, o_rddata holds the head word and o_rdvalid=1.
  - A word written into an empty FIFO is visible on o_rddata in the same cycle o_empty deasserts (one cycle after the write).
  - Read accept advances to the next word on the following cycle.
- Flush (i_flush=1):
  - Next edge: pointers and count to 0; flags take their reset values.
  - Overrides i_wren/i_rden in the same cycle; those requests are dropped and set no error flags.
  - Sticky errors are preserved.
- Sticky errors:
  - Set by a rejected request; hold until i_clr_err.
  - Simultaneous set and clear: set wins.
- Data order strictly FIFO; no data loss or duplication across pointer wrap.
- Illegal parameters (non-power-of-two DEPTH, thresholds out of range) are rejected at elaboration.

Test Plan:
Configuration for all scenarios: DATA_WIDTH=32, DEPTH=16, ALM_FULL_TH=4, ALM_EMPTY_TH=2.
1. Assert rstn=0 mid-write burst -> outputs immediately take reset values (empty=1, alm_empty=1, count=0, errors=0). Rdata 0.
2. Write 0..16 back-to-back (FWFT=0):
   - o_alm_empty drops when count=3.
   - o_alm_full rises when count=12.
   - o_full rises when count=16.
   - 17th write rejected -> overflow=1, count stays 16.
3. Read 17 times from full (FWFT=0) -> o_rddata 0..15 in order, each one cycle after rden with o_rdvalid pulse. 17th read -> underflow=1, empty=1. i_clr_err -> both errors cleared.
4. Fill to 8, then simultaneous wren/rden for 40 cycles -> count stays 8, output sequence contiguous across pointer wrap. Full+wren+rden -> read taken, overflow set.
5. FWFT=1: write 0xA5 to empty -> next cycle empty=0, o_rdvalid=1, o_rddata=0xA5 with no rden. Pop -> empty=1 the following cycle.
6. At count=10 (FWFT=0), assert i_flush with i_wren=1 -> count=0, empty=1, alm_empty=1, write dropped, overflow unchanged. Subsequent write/read returns the new word.
